// File: rtl/data_sram_resp_pkg.sv
// Shared types and defaults for the data SRAM response model.
package data_sram_resp_pkg;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'b00,
        SZ_HALF = 2'b01,
        SZ_WORD = 2'b10
    } size_e;

    localparam int DEF_LATENCY = 2;
    localparam int DEF_QDEPTH  = 2;

    // Widest possible word index (addr[31:2]); the top uses the low MEM_AW bits.
    localparam int IDX_W = 30;
    // Countdown holds LATENCY-1, and LATENCY tops out at 7.
    localparam int CNT_W = 3;

    typedef struct packed {
        logic             wr;
        logic [IDX_W-1:0] idx;
        logic [3:0]       wstrb;
        logic [31:0]      wdata;
        logic [CNT_W-1:0] cnt;
    } q_entry_t;

    // Replace only the byte lanes selected by strb.
    function automatic logic [31:0] merge_lanes(input logic [31:0] old_word,
                                                input logic [31:0] new_word,
                                                input logic [3:0]  strb);
        logic [31:0] res;
        res = old_word;
        for (int b = 0; b < 4; b++) begin
            if (strb[b]) res[8*b +: 8] = new_word[8*b +: 8];
        end
        return res;
    endfunction

endpackage

// File: rtl/data_sram_resp_queue.sv
// In-order FIFO of accepted requests; every slot carries its own countdown.
module resp_queue
    import data_sram_resp_pkg::*;
#(
    parameter int DEPTH = DEF_QDEPTH
) (
    input  logic                       clk,
    input  logic                       resetn,
    input  logic                       push,
    input  q_entry_t                   push_entry,
    input  logic                       pop,
    output q_entry_t                   head,
    output logic                       head_valid,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int OCC_W = $clog2(DEPTH+1);

    q_entry_t         slots [DEPTH];
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic [OCC_W-1:0] occ;
    logic             do_push;
    logic             do_pop;

    // Pointers wrap at DEPTH, which need not be a power of two.
    function automatic logic [PTR_W-1:0] bump(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH-1)) ? '0 : p + PTR_W'(1);
    endfunction

    assign do_push    = push && (occ != OCC_W'(DEPTH));
    assign do_pop     = pop  && (occ != '0);
    assign head       = slots[rd_ptr];
    assign head_valid = (occ != '0);
    assign count      = occ;

    // Load a slot on push; otherwise every slot counts down, stopping at zero.
    // NOTE: slot payloads carry no reset; occ alone says which slots are live.
    // NOTE: sequential state uses <= so all slots update from pre-edge values.
    always_ff @(posedge clk) begin
        for (int i = 0; i < DEPTH; i++) begin
            if (do_push && (wr_ptr == PTR_W'(i))) begin
                slots[i] <= push_entry;
            end else if (slots[i].cnt != '0) begin
                slots[i].cnt <= slots[i].cnt - CNT_W'(1);
            end
        end
    end

    // Pointer and occupancy bookkeeping; reset empties the queue.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            occ    <= '0;
        end else begin
            if (do_push) wr_ptr <= bump(wr_ptr);
            if (do_pop)  rd_ptr <= bump(rd_ptr);
            case ({do_push, do_pop})
                2'b10:   occ <= occ + OCC_W'(1);
                2'b01:   occ <= occ - OCC_W'(1);
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/data_sram_resp.sv
// Data SRAM with fixed-latency, in-order responses behind a small request queue.
module data_sram_resp
    import data_sram_resp_pkg::*;
#(
    parameter int MEM_AW  = 10,
    parameter int LATENCY = DEF_LATENCY,
    parameter int QDEPTH  = DEF_QDEPTH
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        req,
    input  logic        wr,
    input  logic [1:0]  size,
    input  logic [31:0] addr,
    input  logic [3:0]  wstrb,
    input  logic [31:0] wdata,
    output logic        addr_ok,
    output logic        data_ok,
    output logic [31:0] rdata
);

    localparam int OCC_W = $clog2(QDEPTH+1);

    q_entry_t          push_entry;
    q_entry_t          head;
    logic              head_valid;
    logic [OCC_W-1:0]  occ;
    logic [MEM_AW-1:0] head_idx;
    logic [31:0]       rdata_q;
    logic              unused_bits;
    logic [31:0]       mem [2**MEM_AW];

    // Acceptance depends on occupancy only, so a retiring head never frees a
    // slot for the same cycle.
    assign addr_ok  = req && (occ < OCC_W'(QDEPTH));
    assign data_ok  = head_valid && (head.cnt == '0);
    assign head_idx = head.idx[MEM_AW-1:0];

    // Size is informational and the byte offset is aligned away.
    assign unused_bits = ^{size, addr[1:0], addr[31:MEM_AW+2], head.idx[IDX_W-1:MEM_AW]};

    // Build the queue entry for the request presented this cycle.
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        push_entry       = '0;
        push_entry.wr    = wr;
        push_entry.idx   = IDX_W'(addr[MEM_AW+1:2]);
        push_entry.wstrb = wstrb;
        push_entry.wdata = wdata;
        push_entry.cnt   = CNT_W'(LATENCY - 1);
    end

    resp_queue #(
        .DEPTH (QDEPTH)
    ) u_queue (
        .clk        (clk),
        .resetn     (resetn),
        .push       (addr_ok),
        .push_entry (push_entry),
        .pop        (data_ok),
        .head       (head),
        .head_valid (head_valid),
        .count      (occ)
    );

    // A retiring write merges its enabled lanes into the addressed word.
    always_ff @(posedge clk) begin
        if (data_ok && head.wr) begin
            mem[head_idx] <= merge_lanes(mem[head_idx], head.wdata, head.wstrb);
        end
    end

    // Read data during a read response, zero during a write response, else hold.
    always_comb begin
        rdata = rdata_q;
        if (data_ok) rdata = head.wr ? '0 : mem[head_idx];
    end

    // Remember the last presented response value so rdata holds between pulses.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn)      rdata_q <= '0;
        else if (data_ok) rdata_q <= rdata;
    end

endmodule

// File: tb/tb_data_sram_resp.sv
// Scoreboard bench for data_sram_resp: ordering, merging, back-pressure, reset, latency.
module tb_data_sram_resp;

    logic        clk;
    logic        resetn;
    logic        req;
    logic        wr;
    logic [1:0]  size;
    logic [31:0] addr;
    logic [3:0]  wstrb;
    logic [31:0] wdata;
    logic        addr_ok, data_ok;
    logic [31:0] rdata;

    logic        req_lat;
    int          lat_sel;
    logic        req1, aok1, dok1;
    logic        req7, aok7, dok7;
    logic [31:0] rd1, rd7;
    logic        lat_aok, lat_dok;
    logic [31:0] lat_rd;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int resp_cnt = 0;
    logic [31:0] last_rd = '0;

    typedef struct {
        logic        w;
        logic [31:0] a;
        logic [3:0]  s;
        logic [31:0] d;
        int          acc;
    } txn_t;

    txn_t        exp_q [$];
    logic [31:0] model [int];

    data_sram_resp #(.MEM_AW(10), .LATENCY(2), .QDEPTH(2)) dut (
        .clk(clk), .resetn(resetn), .req(req), .wr(wr), .size(size), .addr(addr),
        .wstrb(wstrb), .wdata(wdata), .addr_ok(addr_ok), .data_ok(data_ok), .rdata(rdata)
    );

    data_sram_resp #(.MEM_AW(10), .LATENCY(1), .QDEPTH(2)) dut_l1 (
        .clk(clk), .resetn(resetn), .req(req1), .wr(wr), .size(size), .addr(addr),
        .wstrb(wstrb), .wdata(wdata), .addr_ok(aok1), .data_ok(dok1), .rdata(rd1)
    );

    data_sram_resp #(.MEM_AW(10), .LATENCY(7), .QDEPTH(2)) dut_l7 (
        .clk(clk), .resetn(resetn), .req(req7), .wr(wr), .size(size), .addr(addr),
        .wstrb(wstrb), .wdata(wdata), .addr_ok(aok7), .data_ok(dok7), .rdata(rd7)
    );

    assign req1    = req_lat && (lat_sel == 1);
    assign req7    = req_lat && (lat_sel == 7);
    assign lat_aok = (lat_sel == 1) ? aok1 : aok7;
    assign lat_dok = (lat_sel == 1) ? dok1 : dok7;
    assign lat_rd  = (lat_sel == 1) ? rd1  : rd7;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=0x%08h exp=0x%08h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] apply_strb(input logic [31:0] old_w, input logic [31:0] d,
                                               input logic [3:0] s);
        logic [31:0] m;
        m = {{8{s[3]}}, {8{s[2]}}, {8{s[1]}}, {8{s[0]}}};
        return (old_w & ~m) | (d & m);
    endfunction

    // Monitor: push on acceptance, pop and compare on each response pulse.
    always @(negedge clk) begin
        txn_t        t;
        logic [31:0] exp_rd;
        if (!resetn) begin
            exp_q.delete();
        end else begin
            if (data_ok) begin
                if (exp_q.size() == 0) begin
                    check("spurious_data_ok", 32'(data_ok), 32'd0);
                end else begin
                    t = exp_q.pop_front();
                    resp_cnt++;
                    check("latency", 32'(cyc + 1 - t.acc), 32'd2);
                    if (t.w) begin
                        check("wr_rdata_zero", rdata, 32'd0);
                        exp_rd = model.exists(int'(t.a[31:2])) ? model[int'(t.a[31:2])] : 32'd0;
                        model[int'(t.a[31:2])] = apply_strb(exp_rd, t.d, t.s);
                    end else begin
                        exp_rd = model.exists(int'(t.a[31:2])) ? model[int'(t.a[31:2])] : 32'd0;
                        check("rd_data", rdata, exp_rd);
                        last_rd = rdata;
                    end
                end
            end
            if (req && addr_ok) begin
                t.w = wr; t.a = addr; t.s = wstrb; t.d = wdata; t.acc = cyc + 1;
                exp_q.push_back(t);
            end
        end
    end

    // Present one request from posedge+1 until it is accepted; returns at posedge+1.
    task automatic issue(input logic w, input logic [31:0] a, input logic [3:0] s,
                         input logic [31:0] d);
        int n;
        n = 0;
        req = 1'b1; wr = w; addr = a; wstrb = s; wdata = d;
        @(negedge clk);
        while (!addr_ok && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!addr_ok) check("accept_timeout", 32'(addr_ok), 32'd1);
        @(posedge clk);
        #1;
        req = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 100) begin
            @(posedge clk);
            n++;
        end
        #1;
        check("drain", 32'(exp_q.size()), 32'd0);
    endtask

    // Single request into the LATENCY=1 or LATENCY=7 instance; counts cycles to data_ok.
    task automatic lat_one(input int lat, input logic w, input logic [31:0] d,
                           output logic [31:0] rd);
        int n;
        lat_sel = lat;
        req_lat = 1'b1; wr = w; addr = 32'h50; wstrb = 4'hF; wdata = d;
        @(negedge clk);
        check($sformatf("lat%0d_aok", lat), 32'(lat_aok), 32'd1);
        @(posedge clk);
        #1;
        req_lat = 1'b0;
        @(negedge clk);
        n = 1;
        while (!lat_dok && n < 20) begin
            @(negedge clk);
            n++;
        end
        check($sformatf("lat%0d_cycles", lat), 32'(n), 32'(lat));
        rd = lat_rd;
        @(posedge clk);
        #1;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic        exp_aok [6] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
        logic [31:0] rd;
        int          resp_before;

        resetn = 1'b0; req = 1'b0; wr = 1'b0; size = 2'b10;
        addr = '0; wstrb = '0; wdata = '0; req_lat = 1'b0; lat_sel = 0;

        // Reset state.
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_data_ok", 32'(data_ok), 32'd0);
        check("rst_rdata", rdata, 32'd0);
        check("rst_aok_lo", 32'(addr_ok), 32'd0);
        req = 1'b1;
        #1;
        check("rst_aok_hi", 32'(addr_ok), 32'd1);
        req = 1'b0;
        @(posedge clk);
        #1;
        resetn = 1'b1;

        // Write then read the same word; first accept right after reset release.
        issue(1'b1, 32'h10, 4'hF, 32'hDEADBEEF);
        issue(1'b0, 32'h10, 4'h0, 32'h0);
        drain();
        check("wr_rd_10", last_rd, 32'hDEADBEEF);
        check("rdata_hold", rdata, 32'hDEADBEEF);

        // Single-lane merge, read through an unaligned address.
        issue(1'b1, 32'h20, 4'hF, 32'h11223344);
        issue(1'b1, 32'h20, 4'b0010, 32'h0000AA00);
        issue(1'b0, 32'h22, 4'h0, 32'h0);
        drain();
        check("merge_22", last_rd, 32'h1122AA44);

        // Write immediately followed by a read of the same word, both queued.
        issue(1'b1, 32'h30, 4'hF, 32'h00000005);
        issue(1'b0, 32'h30, 4'h0, 32'h0);
        drain();
        check("hazard_30", last_rd, 32'h00000005);

        // Four back-to-back reads with req held high.
        resp_before = resp_cnt;
        req = 1'b1; wr = 1'b0; addr = 32'h10; wstrb = 4'h0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check($sformatf("b2b_aok%0d", i), 32'(addr_ok), 32'(exp_aok[i]));
            @(posedge clk);
            #1;
        end
        req = 1'b0;
        drain();
        check("b2b_resp", 32'(resp_cnt - resp_before), 32'd4);

        // Reset while a write is still queued.
        issue(1'b1, 32'h40, 4'hF, 32'hCAFEF00D);
        drain();
        issue(1'b1, 32'h40, 4'hF, 32'h12345678);
        resetn = 1'b0;
        @(negedge clk);
        check("midrst_data_ok", 32'(data_ok), 32'd0);
        check("midrst_rdata", rdata, 32'd0);
        check("midrst_aok_lo", 32'(addr_ok), 32'd0);
        req = 1'b1;
        #1;
        check("midrst_aok_hi", 32'(addr_ok), 32'd1);
        req = 1'b0;
        @(negedge clk);
        check("midrst_data_ok2", 32'(data_ok), 32'd0);
        @(posedge clk);
        #1;
        resetn = 1'b1;
        issue(1'b0, 32'h40, 4'h0, 32'h0);
        drain();
        check("rst_kept_40", last_rd, 32'hCAFEF00D);

        // Latency sweep on the LATENCY=1 and LATENCY=7 instances.
        lat_one(1, 1'b1, 32'hA5A50001, rd);
        lat_one(1, 1'b0, 32'h0, rd);
        check("lat1_rd", rd, 32'hA5A50001);
        lat_one(7, 1'b1, 32'h77770007, rd);
        lat_one(7, 1'b0, 32'h0, rd);
        check("lat7_rd", rd, 32'h77770007);

        repeat (3) @(posedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/data_sram_resp.md
DATA_SRAM_RESP -- requirements
Module: data_sram_resp

Interface
REQ-001 Parameter MEM_AW, 10, word-address width; memory depth is 2^MEM_AW 32-bit words.
REQ-002 Parameter LATENCY, 2, cycles from the accepting edge to data_ok; legal range 1..7.
REQ-003 Parameter QDEPTH, 2, maximum number of outstanding accepted requests.
REQ-004 clk  in  1  single clock; all state updates on its rising edge.
REQ-005 resetn  in  1  reset, asynchronous and active-low.
REQ-006 req  in  1  initiator (memory stage) request valid.
REQ-007 wr  in  1  1 = write, 0 = read.
REQ-008 size  in  2  00 byte, 01 half, 10 word; informational only, wstrb governs writes.
REQ-009 addr  in  32  byte address.
REQ-010 wstrb  in  4  byte-lane write enables; ignored on reads.
REQ-011 wdata  in  32  write data, lane-aligned.
REQ-012 addr_ok  out  1  request accepted this cycle when req is also high.
REQ-013 data_ok  out  1  one-cycle response pulse, one per accepted request.
REQ-014 rdata  out  32  read data, valid only while data_ok is high for a read.

Function
REQ-015 addr_ok SHALL equal req AND (queue occupancy < QDEPTH), with no combinational dependence on data_ok or retire.
REQ-016 Acceptance SHALL occur at a rising edge where req and addr_ok are both high; the queue entry captures wr, word index addr[MEM_AW+1:2], wstrb, wdata, and a countdown of LATENCY-1.
REQ-017 addr[1:0] SHALL be ignored for indexing; the word is always aligned down.
REQ-018 Entry countdowns SHALL decrement every cycle, saturating at 0.
REQ-019 The head entry SHALL retire at an edge when its countdown is 0, giving data_ok high for exactly the cycle after that edge (accept at edge N gives data_ok high between edges N+LATENCY-1 and N+LATENCY, sampled at edge N+LATENCY).
REQ-020 Responses SHALL be strictly in acceptance order; one retire per cycle at most.
REQ-021 Write retire SHALL merge wdata into the memory word per wstrb lane at the retire edge; rdata SHALL read 0 during a write's data_ok.
REQ-022 Read retire SHALL drive rdata with the full memory word as of the retire edge, including any earlier-queued write already retired.
REQ-023 Accept and retire in the same cycle SHALL both take effect; occupancy is unchanged.
REQ-024 At full occupancy addr_ok SHALL be low even if the head retires that cycle; the request is accepted on a later cycle.
REQ-025 Occupancy SHALL never exceed QDEPTH or underflow; the queue pointers wrap modulo QDEPTH.
REQ-026 rdata SHALL hold its last value when data_ok is low.

Reset
REQ-027 While resetn is low: the queue is empty, data_ok = 0, rdata = 0, and addr_ok = req.
REQ-028 Reset mid-operation SHALL discard all outstanding requests without responding or committing queued writes; memory contents are not cleared.
REQ-029 The first acceptance is possible at the first rising edge after resetn deasserts.

Structure
REQ-030 A shared package SHALL hold the size encodings (SZ_BYTE, SZ_HALF, SZ_WORD), the default LATENCY and QDEPTH, and the queue entry struct {wr, idx, wstrb, wdata, cnt}.
REQ-031 The queue SHALL be a sub-module resp_queue (a parameterised FIFO exposing per-entry countdown, head view, push, and pop); memory and retire logic live in data_sram_resp.

Verification
REQ-032 Use LATENCY=2. Write addr 0x10, wstrb 1111, data 0xDEADBEEF; then read 0x10. Required: two data_ok pulses in order, and the read returns 0xDEADBEEF exactly 2 cycles after its accept.
REQ-033 Word 0x20 = 0x11223344. Write wstrb 0010, wdata 0x0000AA00; then read 0x22. Required: rdata = 0x1122AA44.
REQ-034 Hold req high for 4 back-to-back reads with QDEPTH=2. Required: addr_ok drops after 2 accepts and reasserts one cycle after the first data_ok; 4 data_ok pulses arrive in order with no loss.
REQ-035 Write 0x30 = 0x5 followed immediately by a read of 0x30, both queued. Required: the read returns 0x5 (ordering hazard).
REQ-036 Accept a write to 0x40, then pulse resetn low before its data_ok. Required: no data_ok, the word at 0x40 keeps its prior value, and addr_ok = req during reset.
REQ-037 Sweep LATENCY=1 and 7. Required: data_ok arrives exactly LATENCY cycles after accept for single requests.
